fifo_tx_serializer: RTL and testbench

//   Consumer end of the 8x32 word queue: pops words from the queue's read side and

---
 rtl/fifo_tx_serializer.sv | 180 ++++++++++++++++++
 tb/tb_fifo_tx_serializer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_serializer.sv
// Purpose : pops words from the 8x32 queue's read side and sends each one as an async
//           serial frame: start(0), WORD_LENGTH data bits LSB first, [parity], stop(1).
// Latency : tx_out falls 2 cycles after the fifo_rd cycle; the frame lasts
//           (WORD_LENGTH+2[+1])*CLKS_PER_BIT cycles.
// Backpressure: pops only from IDLE when tx_enable=1 and fifo_empty=0. A running frame
//           always completes unless reset is asserted.
// Optional feature: define FIFO_TX_PARITY_EN to add an even-parity bit after the data.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   tx_enable      permits popping a new word from the queue
//   fifo_empty     queue stack_empty; sampled only in IDLE
//   fifo_data      queue data_out; captured at the end of LOAD
//   fifo_rd        queue read_from_stack strobe; one cycle, registered
//   tx_out         serial line, idles high
//   busy           high in every state except IDLE
//   frame_done     one-cycle pulse in the last cycle of the stop bit
//   frame_count    completed-frame counter; wraps silently
module fifo_tx_serializer #(
    parameter int WORD_LENGTH  = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tx_enable,
    input  logic                   fifo_empty,
    input  logic [WORD_LENGTH-1:0] fifo_data,
    output logic                   fifo_rd,
    output logic                   tx_out,
    output logic                   busy,
    output logic                   frame_done,
    output logic [COUNT_WIDTH-1:0] frame_count
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(WORD_LENGTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    // frame_done is registered, so it is raised one cycle before the stop bit ends.
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef FIFO_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                 state_q;
    logic [BAUD_W-1:0]      baud_q;
    logic [BIT_W-1:0]       bit_q;
    logic [WORD_LENGTH-1:0] shift_q;
    logic                   tx_q;
    logic                   rd_q;
    logic                   busy_q;
    logic                   done_q;
    logic [COUNT_WIDTH-1:0] count_q;
`ifdef FIFO_TX_PARITY_EN
    logic                   parity_q;
`endif

    wire baud_last = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            rd_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
`ifdef FIFO_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            rd_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (tx_enable && !fifo_empty) begin
                        state_q <= S_POP;
                        rd_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_POP: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    // Queue output is valid one cycle after the read strobe.
                    shift_q  <= fifo_data;
`ifdef FIFO_TX_PARITY_EN
                    parity_q <= ^fifo_data;
`endif
                    tx_q     <= 1'b0;
                    baud_q   <= '0;
                    state_q  <= S_START;
                end
                S_START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        shift_q <= shift_q >> 1;
                        if (bit_q == BIT_LAST) begin
                            bit_q   <= '0;
`ifdef FIFO_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            // Next bit is what becomes shift[0] after this shift.
                            tx_q  <= shift_q[1];
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
`ifdef FIFO_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (baud_q == BAUD_PRE) begin
                        done_q  <= 1'b1;
                        count_q <= count_q + COUNT_WIDTH'(1);
                    end
                    if (baud_last) begin
                        baud_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign fifo_rd     = rd_q;
    assign tx_out      = tx_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Purpose : self-checking bench for fifo_tx_serializer with a queue model and a
//           serial-line monitor fed by a scoreboard of popped words.
// Latency : n/a (testbench)
// Backpressure: queue model pops only on fifo_rd and drives fifo_empty from its depth.
module tb_fifo_tx_serializer;

    localparam int WL = 8;
    localparam int C  = 4;
    localparam int CW = 16;
`ifdef FIFO_TX_PARITY_EN
    localparam int NB = WL + 3;
`else
    localparam int NB = WL + 2;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tx_enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [WL-1:0] fifo_data = '0;
    logic          fifo_rd;
    logic          tx_out;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] frame_count;

    int checks = 0;
    int errors = 0;

    fifo_tx_serializer #(.WORD_LENGTH(WL), .CLKS_PER_BIT(C), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .tx_enable(tx_enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd(fifo_rd), .tx_out(tx_out), .busy(busy),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Queue model: data appears one cycle after the read strobe; random otherwise.
    logic [WL-1:0] fifo_q[$];
    logic [WL-1:0] sb[$];
    always @(posedge clk) begin
        logic [WL-1:0] w;
        bit popped;
        popped = 1'b0;
        w = '0;
        if (!reset && fifo_rd === 1'b1) begin
            checks++;
            if (fifo_q.size() == 0) begin
                errors++;
                $display("FAIL pop_on_empty: fifo_rd=1 with queue depth 0, required no pop");
            end else begin
                w = fifo_q.pop_front();
                sb.push_back(w);
                popped = 1'b1;
            end
        end
        #1;
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = popped ? w : WL'($urandom);
    end

    // Serial-line monitor.
    int  rd_cycs[$], done_cycs[$], start_cycs[$];
    int  rd_total = 0, done_total = 0;
    bit  prev_rd = 1'b0;
    bit  mon_active = 1'b0, mon_skip = 1'b0;
    int  mon_cnt = 0;
    logic [NB-1:0] fbits;
    always @(negedge clk) begin
        logic [WL-1:0] w;
        if (fifo_rd === 1'b1) begin
            rd_cycs.push_back(cyc);
            rd_total++;
            checks++;
            if (prev_rd) begin
                errors++;
                $display("FAIL fifo_rd_width: high for 2+ cycles, required 1 cycle");
            end
        end
        prev_rd = (fifo_rd === 1'b1);
        if (frame_done === 1'b1) begin
            done_cycs.push_back(cyc);
            done_total++;
        end
        if (reset) begin
            mon_active = 1'b0;
            sb.delete();
        end else begin
            if (!mon_active) begin
                checks++;
                if (frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_done_idle: got %b outside a frame, required 0", frame_done);
                end
                if (tx_out === 1'b0) begin
                    start_cycs.push_back(cyc);
                    mon_active = 1'b1;
                    mon_cnt = 0;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        mon_skip = 1'b1;
                        $display("FAIL unexpected_start: tx_out fell with no popped word, required idle 1");
                    end else begin
                        mon_skip = 1'b0;
                        w = sb.pop_front();
                        fbits = '0;
                        for (int i = 0; i < WL; i++) fbits[1+i] = w[i];
`ifdef FIFO_TX_PARITY_EN
                        fbits[WL+1] = ^w;
`endif
                        fbits[NB-1] = 1'b1;
                    end
                end
            end
            if (mon_active) begin
                if (!mon_skip) begin
                    checks++;
                    if (tx_out !== fbits[mon_cnt / C]) begin
                        errors++;
                        $display("FAIL tx_bit: frame bit %0d cycle %0d got %b, required %b",
                                 mon_cnt / C, mon_cnt % C, tx_out, fbits[mon_cnt / C]);
                    end
                    checks++;
                    if (frame_done !== (mon_cnt == NB*C-1)) begin
                        errors++;
                        $display("FAIL frame_done_pos: at frame cycle %0d got %b, required %b",
                                 mon_cnt, frame_done, (mon_cnt == NB*C-1));
                    end
                end
                mon_cnt++;
                if (mon_cnt == NB*C) mon_active = 1'b0;
            end
        end
    end

    task automatic do_reset();
        tx_enable = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tx_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (tx_out !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0 ||
                frame_done !== 1'b0 || frame_count !== '0) begin
                errors++;
                $display("FAIL reset_hold: tx=%b busy=%b rd=%b done=%b cnt=%0d, required 1 0 0 0 0",
                         tx_out, busy, fifo_rd, frame_done, frame_count);
            end
        end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (tx_out !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0 || frame_count !== '0) begin
                errors++;
                $display("FAIL reset_release: tx=%b busy=%b rd=%b cnt=%0d, required 1 0 0 0",
                         tx_out, busy, fifo_rd, frame_count);
            end
        end
    endtask

    task automatic test_single_a5();
        int rd0, d0, n;
        rd0 = rd_total;
        d0 = done_total;
        tx_enable = 1'b1;
        fifo_q.push_back(8'hA5);
        n = 0;
        while (done_total == d0 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (done_total == d0) begin
            errors++;
            $display("FAIL single_timeout: no frame_done in 200 cycles, required one");
        end
        repeat (8) @(negedge clk);
        checks++;
        if (rd_total - rd0 != 1) begin
            errors++;
            $display("FAIL single_rd_count: got %0d pops, required 1", rd_total - rd0);
        end
        checks++;
        if (done_total - d0 != 1) begin
            errors++;
            $display("FAIL single_done_count: got %0d pulses, required 1", done_total - d0);
        end
        checks++;
        if (frame_count !== CW'(1)) begin
            errors++;
            $display("FAIL single_frame_count: got %0d, required 1", frame_count);
        end
        checks++;
        if (rd_cycs.size() == 0 || start_cycs.size() == 0 ||
            start_cycs[$] - rd_cycs[$] != 2) begin
            errors++;
            $display("FAIL single_start_latency: start-rd distance wrong, required 2 cycles");
        end
        checks++;
        if (busy !== 1'b0 || mon_active) begin
            errors++;
            $display("FAIL single_end_idle: busy=%b active=%b, required 0 0", busy, mon_active);
        end
    endtask

    task automatic test_idle_empty();
        tx_enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_rd !== 1'b0 || tx_out !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_empty: rd=%b tx=%b busy=%b, required 0 1 0", fifo_rd, tx_out, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int rd0, d0, s0, dc0, n;
        do_reset();
        rd0 = rd_cycs.size();
        dc0 = done_cycs.size();
        s0 = start_cycs.size();
        d0 = done_total;
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        fifo_q.push_back(8'h3C);
        tx_enable = 1'b1;
        n = 0;
        while (done_total - d0 < 3 && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (done_total - d0 < 3) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d frames in 500 cycles, required 3", done_total - d0);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (rd_cycs.size() - rd0 != 3) begin
            errors++;
            $display("FAIL b2b_rd_count: got %0d pops, required 3 (no pop when empty)",
                     rd_cycs.size() - rd0);
        end
        checks++;
        if (frame_count !== CW'(3)) begin
            errors++;
            $display("FAIL b2b_frame_count: got %0d, required 3", frame_count);
        end
        if (rd_cycs.size() - rd0 == 3 && done_cycs.size() - dc0 == 3 && start_cycs.size() - s0 == 3) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (rd_cycs[rd0+i+1] - done_cycs[dc0+i] != 2) begin
                    errors++;
                    $display("FAIL b2b_rd_gap: frame %0d rd-done distance %0d, required 2",
                             i, rd_cycs[rd0+i+1] - done_cycs[dc0+i]);
                end
                checks++;
                if (start_cycs[s0+i+1] - done_cycs[dc0+i] != 4) begin
                    errors++;
                    $display("FAIL b2b_start_gap: frame %0d start-done distance %0d, required 4",
                             i, start_cycs[s0+i+1] - done_cycs[dc0+i]);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        int rd0, d0, n;
        do_reset();
        rd0 = rd_total;
        d0 = done_total;
        fifo_q.push_back(8'h5A);
        fifo_q.push_back(8'h11);
        tx_enable = 1'b1;
        n = 0;
        while (rd_total == rd0 && n < 50) begin @(negedge clk); n++; end
        // rd seen at negedge k; frame cycle 17 (DATA bit 3) is negedge k+19.
        repeat (19) @(negedge clk);
        tx_enable = 1'b0;
        n = 0;
        while (done_total == d0 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (done_total - d0 != 1) begin
            errors++;
            $display("FAIL drop_frame_done: got %0d pulses, required 1", done_total - d0);
        end
        repeat (30) @(negedge clk);
        checks++;
        if (rd_total - rd0 != 1) begin
            errors++;
            $display("FAIL drop_no_pop: got %0d pops, required 1", rd_total - rd0);
        end
        checks++;
        if (fifo_q.size() != 1 || busy !== 1'b0 || frame_count !== CW'(1)) begin
            errors++;
            $display("FAIL drop_state: depth=%0d busy=%b cnt=%0d, required 1 0 1",
                     fifo_q.size(), busy, frame_count);
        end
        fifo_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int rd0, n;
        rd0 = rd_total;
        fifo_q.push_back(8'h96);
        tx_enable = 1'b1;
        n = 0;
        while (rd_total == rd0 && n < 50) begin @(negedge clk); n++; end
        repeat (12) @(negedge clk);
        tx_enable = 1'b0;
        checks++;
        if (busy !== 1'b1 || frame_count !== CW'(1)) begin
            errors++;
            $display("FAIL midreset_before: busy=%b cnt=%0d, required 1 1", busy, frame_count);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || frame_count !== '0 || fifo_rd !== 1'b0) begin
            errors++;
            $display("FAIL midreset_after: tx=%b busy=%b cnt=%0d rd=%b, required 1 0 0 0",
                     tx_out, busy, frame_count, fifo_rd);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (50) @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || frame_count !== '0) begin
            errors++;
            $display("FAIL midreset_quiet: tx=%b busy=%b cnt=%0d, required 1 0 0",
                     tx_out, busy, frame_count);
        end
    endtask

`ifdef FIFO_TX_PARITY_EN
    task automatic test_parity();
        int s0, n;
        s0 = start_cycs.size();
        fifo_q.push_back(8'h07);
        tx_enable = 1'b1;
        n = 0;
        while (start_cycs.size() == s0 && n < 50) begin @(negedge clk); n++; end
        // At start-detect negedge (frame cycle 0); parity bit covers cycles 36..39.
        repeat (9*C + 1) @(negedge clk);
        checks++;
        if (tx_out !== 1'b1) begin
            errors++;
            $display("FAIL parity_07: parity bit got %b, required 1", tx_out);
        end
        tx_enable = 1'b0;
        repeat (20) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_a5();
        test_idle_empty();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
`ifdef FIFO_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
